// File: rtl/seg7_scan.sv
// seg7_scan: snapshots a six-digit BCD frame and scans a common-anode 7-segment display
// with a dark gap after each digit change. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] digits,
  input  logic [5:0]  dp,
  output logic [5:0]  sel_n,
  output logic [7:0]  seg_n
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [23:0]      frame_dig_q, frame_dig_d;
  logic [5:0]       frame_dp_q, frame_dp_d;
  logic [5:0]       sel_n_q, sel_n_d;
  logic [7:0]       seg_n_q, seg_n_d;
  logic             tick_s;
  logic [3:0]       nib_s;
  logic             dp_s;
  logic [6:0]       glyph_s;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

`ifdef SEG7_LZB_EN
  // Highest digit position holding a non-zero nibble; 0 when the whole frame is zero.
  function automatic logic [2:0] top_digit(input logic [23:0] frame);
    logic [2:0] t;
    t = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (frame[i*4 +: 4] != 4'd0) t = 3'(i);
      else                          t = t;
    end
    return t;
  endfunction
`endif

  // Next-state logic for prescaler, digit index and frame snapshot.
  always_comb begin
    tick_s      = (cnt_q == CNT_LAST);
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_dig_d = frame_dig_q;
    frame_dp_d  = frame_dp_q;
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == 3'd5) begin
        idx_d       = 3'd0;
        frame_dig_d = digits;
        frame_dp_d  = dp;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Output decode from the current (pre-edge) state; registered below.
  always_comb begin
    nib_s   = 4'd0;
    dp_s    = 1'b0;
    sel_n_d = 6'h3F;
    case (idx_q)
      3'd0:    begin nib_s = frame_dig_q[3:0];   dp_s = frame_dp_q[0]; end
      3'd1:    begin nib_s = frame_dig_q[7:4];   dp_s = frame_dp_q[1]; end
      3'd2:    begin nib_s = frame_dig_q[11:8];  dp_s = frame_dp_q[2]; end
      3'd3:    begin nib_s = frame_dig_q[15:12]; dp_s = frame_dp_q[3]; end
      3'd4:    begin nib_s = frame_dig_q[19:16]; dp_s = frame_dp_q[4]; end
      3'd5:    begin nib_s = frame_dig_q[23:20]; dp_s = frame_dp_q[5]; end
      default: begin nib_s = 4'd0;               dp_s = 1'b0;          end
    endcase
    glyph_s = bcd_to_seg(nib_s);
`ifdef SEG7_LZB_EN
    if (idx_q > top_digit(frame_dig_q)) glyph_s = 7'h7F;
    else                                glyph_s = glyph_s;
`endif
    seg_n_d = {~dp_s, glyph_s};
    if (!en || (cnt_q < CNT_BLANK)) begin
      sel_n_d = 6'h3F;
    end else begin
      case (idx_q)
        3'd0:    sel_n_d = 6'h3E;
        3'd1:    sel_n_d = 6'h3D;
        3'd2:    sel_n_d = 6'h3B;
        3'd3:    sel_n_d = 6'h37;
        3'd4:    sel_n_d = 6'h2F;
        3'd5:    sel_n_d = 6'h1F;
        default: sel_n_d = 6'h3F;
      endcase
    end
  end

  // State and output registers; reset leaves the display dark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= {CNT_W{1'b0}};
      idx_q       <= 3'd0;
      frame_dig_q <= 24'h000000;
      frame_dp_q  <= 6'h00;
      sel_n_q     <= 6'h3F;
      seg_n_q     <= 8'hFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_dig_q <= frame_dig_d;
      frame_dp_q  <= frame_dp_d;
      sel_n_q     <= sel_n_d;
      seg_n_q     <= seg_n_d;
    end
  end

  assign sel_n = sel_n_q;
  assign seg_n = seg_n_q;

endmodule
